// File: rtl/camera_capture_ctrl.sv
// Camera parallel-port capture controller: turns FVAL/LVAL-framed video into a
// valid/sop/eop pixel stream, with an Avalon-MM control, status and measurement block.
`timescale 1ns/1ps
module camera_capture_ctrl #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] cam_d,
    input  logic              cam_fval,
    input  logic              cam_lval,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              pix_sop,
    output logic              pix_eop,
    input  logic              pix_ready,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM      = 2'd1,
        ST_WAIT_SOF = 2'd2,
        ST_CAPTURE  = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_WIDTH  = 3'd2;
    localparam logic [2:0] ADDR_HEIGHT = 3'd3;
    localparam logic [2:0] ADDR_FCNT   = 3'd4;
    localparam logic [2:0] ADDR_MEAS   = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counters stick at all-ones instead of wrapping so oversize input stays detectable.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    // Input stage and edge-detect history
    logic [DATA_W-1:0] d_r;
    logic              fval_r, lval_r, fval_d_r, lval_d_r;
    logic              fval_rise_s, fval_fall_s, lval_fall_s;

    // Register file
    logic              cont_r, irq_en_r;
    logic              done_r, size_err_r, ovf_r;
    logic [CNT_W-1:0]  width_r, height_r;
    logic [CNT_W-1:0]  shadow_w_r, shadow_h_r;
    logic [15:0]       frame_cnt_r, frame_cnt_nxt_s;
    logic [CNT_W-1:0]  meas_pix_r, meas_line_r;
    logic [31:0]       rd_mux_s, avs_readdata_r;

    // Capture datapath
    logic [CNT_W-1:0]  pix_cnt_r, line_cnt_r, lines_done_s;
    logic [DATA_W-1:0] pix_data_r;
    logic              pix_valid_r, pix_sop_r, pix_eop_r, irq_r;
    state_t            state_r, state_nxt_s;

    logic              wr_ctrl_s, wr_status_s, start_s, abort_s;
    logic [3:0]        w1c_s;
    logic              busy_s, in_capture_s, pixel_s, in_bounds_s, fwd_s;
    logic              first_s, last_s, line_end_s, frame_end_s, size_err_set_s;
    logic              unused_wdata_s;

    assign wr_ctrl_s   = avs_write & (avs_address == ADDR_CTRL);
    assign wr_status_s = avs_write & (avs_address == ADDR_STATUS);
    assign start_s     = wr_ctrl_s & avs_writedata[0];
    assign abort_s     = wr_ctrl_s & avs_writedata[3];
    assign w1c_s       = wr_status_s ? avs_writedata[3:0] : 4'd0;
    assign unused_wdata_s = ^avs_writedata[31:CNT_W];

    assign fval_rise_s = fval_r & ~fval_d_r;
    assign fval_fall_s = ~fval_r & fval_d_r;
    assign lval_fall_s = ~lval_r & lval_d_r;

    assign busy_s       = (state_r != ST_IDLE);
    assign in_capture_s = (state_r == ST_CAPTURE);
    assign pixel_s      = in_capture_s & lval_r;
    assign in_bounds_s  = (pix_cnt_r < shadow_w_r) & (line_cnt_r < shadow_h_r);
    // An abort in the same cycle suppresses the pixel so no eop can leak out.
    assign fwd_s        = pixel_s & in_bounds_s & ~abort_s;
    assign first_s      = (pix_cnt_r == CNT_ZERO) & (line_cnt_r == CNT_ZERO);
    assign last_s       = (pix_cnt_r == shadow_w_r - CNT_ONE) & (line_cnt_r == shadow_h_r - CNT_ONE);
    assign line_end_s   = in_capture_s & lval_fall_s;
    assign frame_end_s  = in_capture_s & fval_fall_s & ~abort_s;
    assign lines_done_s = line_end_s ? sat_inc(line_cnt_r) : line_cnt_r;

    assign size_err_set_s = (pixel_s & ~in_bounds_s)
                          | (line_end_s & (pix_cnt_r != shadow_w_r))
                          | (frame_end_s & (lines_done_s != shadow_h_r));

    assign frame_cnt_nxt_s = frame_end_s ? (frame_cnt_r + 16'd1) : frame_cnt_r;

    // Camera input register stage and previous-value history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            d_r      <= {DATA_W{1'b0}};
            fval_r   <= 1'b0;
            lval_r   <= 1'b0;
            fval_d_r <= 1'b0;
            lval_d_r <= 1'b0;
        end else begin
            d_r      <= cam_d;
            fval_r   <= cam_fval;
            lval_r   <= cam_lval;
            fval_d_r <= fval_r;
            lval_d_r <= lval_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; ARM waits out any frame already in progress
    always_comb begin
        state_nxt_s = state_r;
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s && (width_r != CNT_ZERO) && (height_r != CNT_ZERO)) begin
                        state_nxt_s = ST_ARM;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (!fval_r) begin
                        state_nxt_s = ST_WAIT_SOF;
                    end else begin
                        state_nxt_s = ST_ARM;
                    end
                end
                ST_WAIT_SOF: begin
                    if (fval_rise_s) begin
                        state_nxt_s = ST_CAPTURE;
                    end else begin
                        state_nxt_s = ST_WAIT_SOF;
                    end
                end
                ST_CAPTURE: begin
                    if (fval_fall_s) begin
                        state_nxt_s = cont_r ? ST_WAIT_SOF : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // CTRL, WIDTH/HEIGHT registers and the per-frame shadow copy
    always_ff @(posedge clk) begin
        if (reset) begin
            cont_r     <= 1'b0;
            irq_en_r   <= 1'b0;
            width_r    <= CNT_ZERO;
            height_r   <= CNT_ZERO;
            shadow_w_r <= CNT_ZERO;
            shadow_h_r <= CNT_ZERO;
        end else begin
            if (wr_ctrl_s) begin
                cont_r   <= avs_writedata[1];
                irq_en_r <= avs_writedata[2];
            end
            if (avs_write && (avs_address == ADDR_WIDTH)) begin
                width_r <= avs_writedata[CNT_W-1:0];
            end
            if (avs_write && (avs_address == ADDR_HEIGHT)) begin
                height_r <= avs_writedata[CNT_W-1:0];
            end
            if ((state_r == ST_WAIT_SOF) && fval_rise_s) begin
                shadow_w_r <= width_r;
                shadow_h_r <= height_r;
            end
        end
    end

    // Sticky status bits: a hardware set in the same cycle as a W1C clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            done_r     <= 1'b0;
            size_err_r <= 1'b0;
            ovf_r      <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            done_r     <= (done_r & ~w1c_s[1]) | frame_end_s;
            size_err_r <= (size_err_r & ~w1c_s[2]) | size_err_set_s;
            ovf_r      <= (ovf_r & ~w1c_s[3]) | (pix_valid_r & ~pix_ready);
            irq_r      <= irq_en_r & (done_r | size_err_r | ovf_r);
        end
    end

    // Pixel/line position counters and the frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt_r   <= CNT_ZERO;
            line_cnt_r  <= CNT_ZERO;
            frame_cnt_r <= 16'd0;
        end else begin
            frame_cnt_r <= frame_cnt_nxt_s;
            if (fval_rise_s) begin
                pix_cnt_r  <= CNT_ZERO;
                line_cnt_r <= CNT_ZERO;
            end else if (line_end_s) begin
                pix_cnt_r  <= CNT_ZERO;
                line_cnt_r <= sat_inc(line_cnt_r);
            end else if (pixel_s) begin
                pix_cnt_r  <= sat_inc(pix_cnt_r);
            end
        end
    end

    // Measured geometry of the last line and last completed frame
    always_ff @(posedge clk) begin
        if (reset) begin
            meas_pix_r  <= CNT_ZERO;
            meas_line_r <= CNT_ZERO;
        end else begin
            if (line_end_s) begin
                meas_pix_r <= pix_cnt_r;
            end
            if (frame_end_s) begin
                meas_line_r <= lines_done_s;
            end
        end
    end

    // Output stream register; no backpressure, an unaccepted pixel is simply replaced
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_data_r  <= {DATA_W{1'b0}};
            pix_valid_r <= 1'b0;
            pix_sop_r   <= 1'b0;
            pix_eop_r   <= 1'b0;
        end else begin
            pix_valid_r <= fwd_s;
            pix_sop_r   <= fwd_s & first_s;
            pix_eop_r   <= fwd_s & last_s;
            if (fwd_s) begin
                pix_data_r <= d_r;
            end
        end
    end

    // Read-data multiplexer
    always_comb begin
        rd_mux_s = 32'd0;
        case (avs_address)
            ADDR_CTRL:   rd_mux_s[2:1] = {irq_en_r, cont_r};
            ADDR_STATUS: rd_mux_s[3:0] = {ovf_r, size_err_r, done_r, busy_s};
            ADDR_WIDTH:  rd_mux_s[CNT_W-1:0] = width_r;
            ADDR_HEIGHT: rd_mux_s[CNT_W-1:0] = height_r;
            ADDR_FCNT:   rd_mux_s[15:0] = frame_cnt_r;
            ADDR_MEAS: begin
                rd_mux_s[CNT_W-1:0]     = meas_pix_r;
                rd_mux_s[16+CNT_W-1:16] = meas_line_r;
            end
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data, one cycle after the read strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata_r <= 32'd0;
        end else if (avs_read) begin
            avs_readdata_r <= rd_mux_s;
        end
    end

    assign avs_readdata = avs_readdata_r;
    assign pix_data     = pix_data_r;
    assign pix_valid    = pix_valid_r;
    assign pix_sop      = pix_sop_r;
    assign pix_eop      = pix_eop_r;
    assign irq          = irq_r;

endmodule
